// File: rtl/modular_correction_stage.sv
// rtl/modular_correction_stage.sv - modulo-M reduction of the raw sum, 2-deep valid/ready pipeline with drain-before-reconfigure FSM
module modular_correction_stage #(
  parameter int W         = 4,
  parameter int RESET_MOD = 13
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cfg_we,
  input  logic [W-1:0] cfg_mod,
  output logic         cfg_busy,
  output logic         mod_err,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W:0]   in_sum,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_res,
  output logic         out_ovf,
  output logic [7:0]   err_cnt
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  localparam logic [W-1:0] LP_RESET_MOD = W'(RESET_MOD);

  state_t              r_state;
  logic [W-1:0]        r_mod;
  logic [W-1:0]        r_pend;
  logic                r_mod_err;

  logic                r_v1;
  logic [W:0]          r_sum1;
  logic signed [W+1:0] r_diff1;
  logic                r_ovf1;

  logic                r_v2;
  logic [W-1:0]        r_res;
  logic                r_ovf2;
  logic [7:0]          r_err_cnt;

  logic                w_s2_load;
  logic                w_in_ready;
  logic                w_in_accept;
  logic [W+1:0]        w_twice_mod;
  logic                w_ovf;
  logic signed [W+1:0] w_diff;
  logic [W-1:0]        w_res;

  // S2 takes a new entry whenever it is empty or its current one is consumed.
  assign w_s2_load   = !r_v2 || out_ready;
  assign w_in_ready  = (r_state == ST_RUN) && (!r_v1 || w_s2_load);
  assign w_in_accept = in_valid && w_in_ready;

  // Overflow test and trial subtraction both done at full width so no bits are lost.
  assign w_twice_mod = {1'b0, r_mod, 1'b0};
  assign w_ovf       = ({1'b0, in_sum} >= w_twice_mod);
  assign w_diff      = $signed({1'b0, in_sum}) - $signed({2'b00, r_mod});

  // A negative trial difference means the sum was already below M.
  assign w_res = r_ovf1 ? '0 : (r_diff1[W+1] ? r_sum1[W-1:0] : r_diff1[W-1:0]);

  // Stage 1: capture the raw sum with its trial difference and overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1    <= 1'b0;
      r_sum1  <= '0;
      r_diff1 <= '0;
      r_ovf1  <= 1'b0;
    end else if (w_in_accept) begin
      r_v1    <= 1'b1;
      r_sum1  <= in_sum;
      r_diff1 <= w_diff;
      r_ovf1  <= w_ovf;
    end else if (w_s2_load) begin
      r_v1    <= 1'b0;
    end
  end

  // Stage 2: register the residue and count out-of-range entries, saturating at 255.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2      <= 1'b0;
      r_res     <= '0;
      r_ovf2    <= 1'b0;
      r_err_cnt <= '0;
    end else if (w_s2_load) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_res  <= w_res;
        r_ovf2 <= r_ovf1;
        if (r_ovf1 && (r_err_cnt != 8'hFF)) begin
          r_err_cnt <= r_err_cnt + 8'd1;
        end
      end
    end
  end

  // Reconfiguration: accept a legal modulus, wait for both stages to empty, then swap M.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_RUN;
      r_mod     <= LP_RESET_MOD;
      r_pend    <= LP_RESET_MOD;
      r_mod_err <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (cfg_we) begin
            if (cfg_mod >= W'(2)) begin
              r_pend  <= cfg_mod;
              r_state <= ST_DRAIN;
            end else begin
              r_mod_err <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (!r_v1 && !r_v2) begin
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_mod   <= r_pend;
          r_state <= ST_RUN;
        end
        default: begin
          r_state <= ST_RUN;
        end
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_v2;
  assign out_res   = r_res;
  assign out_ovf   = r_ovf2;
  assign err_cnt   = r_err_cnt;
  assign mod_err   = r_mod_err;
  assign cfg_busy  = (r_state != ST_RUN);

endmodule

// File: doc/modular_correction_stage.md
# modular_correction_stage

Third stage of the modular adder/subtractor datapath. Consumes the (W+1)-bit raw sum from the second-stage prefix adder and reduces it modulo a run-time-loadable modulus M, giving a W-bit residue. It is a 2-deep valid/ready pipeline with backpressure, a reconfiguration FSM that drains in-flight data before the modulus changes, and a saturating counter of out-of-range inputs.

## Interface
Parameters:
- W, 4, operand width; the raw-sum input is W+1 bits.
- RESET_MOD, 13, modulus loaded at reset; legal range 2..2^W-1.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_we  in  1  request to load a new modulus.
- cfg_mod  in  W  new modulus value.
- cfg_busy  out  1  high while a reconfiguration is in progress (state != RUN).
- mod_err  out  1  sticky; set on a rejected cfg_mod (< 2). Cleared only by reset.
- in_valid  in  1  raw sum valid.
- in_ready  out  1  stage can accept the raw sum this cycle.
- in_sum  in  W+1  raw sum {out4..out0} from the prefix adder.
- out_valid  out  1  residue valid.
- out_ready  in  1  downstream accepts the residue.
- out_res  out  W  residue.
- out_ovf  out  1  in_sum was >= 2M; out_res forced to 0.
- err_cnt  out  8  saturating count of accepted inputs flagged out_ovf.

## Operation
- Transfer occurs on a cycle with valid && ready, at either port.
- S1 registers: v1, sum1, diff1 = in_sum − M (W+2-bit signed), ovf1 = (in_sum >= 2M).
- S2 registers the outputs: out_res = ovf1 ? 0 : (diff1 < 0 ? sum1[W-1:0] : diff1[W-1:0]); out_ovf = ovf1; out_valid = v2.
- S2 loads when !v2 || out_ready. S1 advances when S2 loads. in_ready = (state == RUN) && (!v1 || S2 loads), computed combinationally.
- err_cnt increments when an S1 entry with ovf1 = 1 moves into S2. It saturates at 255.
- FSM states:
  - RUN: on cfg_we with cfg_mod >= 2, capture pend = cfg_mod and go to DRAIN. On cfg_we with cfg_mod < 2, set mod_err and stay in RUN; M is unchanged.
  - DRAIN: in_ready = 0. When v1 = 0 and v2 = 0, go to LOAD.
  - LOAD: M <= pend, then go to RUN.
- cfg_we in DRAIN or LOAD is ignored; neither pend nor mod_err changes.
- An input accepted in the same cycle as cfg_we in RUN is legal. It is processed with the old M.
- Results leave in acceptance order; none is dropped or duplicated under any backpressure.

## Timing
- Reset values:
  - state = RUN, M = RESET_MOD.
  - v1 = v2 = 0, out_valid = 0, out_res = 0, out_ovf = 0.
  - err_cnt = 0, mod_err = 0, cfg_busy = 0.
  - in_ready = 1 from the first cycle after reset deasserts.
- Latency: an input accepted at edge k gives out_valid = 1 after edge k+1 (2 registers).
- Throughput: 1 result per cycle with out_ready held high.
- Backpressure: with out_ready = 0, at most 2 items are held; in_ready falls in the cycle both S1 and S2 are full.
- Reconfiguration with the pipeline already empty: cfg_we at edge k, DRAIN after k, LOAD after k+1, RUN with the new M after k+2. Minimum in_ready-low window is 2 cycles.
- cfg_busy = 1 exactly in DRAIN and LOAD.
- Asserting rst_n low mid-operation discards in-flight data immediately. All outputs return to their reset values with no clock edge required.

## Test plan
- M = 13, out_ready = 1, sums 12, 13, 24, 0 back-to-back → out_res 12, 0, 11, 0 on 4 consecutive cycles, starting 2 cycles after the first accept; out_ovf = 0 for all four.
- M = 13, sum 26 then 31 → out_ovf = 1 and out_res = 0 for both; err_cnt = 2. Then 300 further out-of-range sums → err_cnt saturates at 255.
- Send sums 1..6 with out_ready = 0 for 4 cycles, then 1 → in_ready drops after 2 accepts; outputs 1..6 appear in order with no loss.
- Send 2 sums (14, 20), then cfg_we with cfg_mod = 7 while they are in flight → results 1 and 7 computed with M = 13; in_ready low until RUN; next sum 9 → out_res 2.
- cfg_we with cfg_mod = 1 → mod_err = 1; M stays 13 and no DRAIN occurs; a second cfg_we during DRAIN is ignored.
- Pull rst_n low with both stages full and a pending reconfiguration → all outputs reset at once; M = 13; the next sum 13 → out_res 0.
